// File: rtl/seq_restoring_divider_pkg.sv
// Shared definitions for the sequential arithmetic blocks (divider now, sequential multiplier later).
package seq_restoring_divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  // Width of an iteration counter that must reach n-1.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/divstep_cell.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, and emit the quotient bit.
module divstep_cell #(
  parameter int bitsize = 8
) (
  input  logic [bitsize-1:0] r_i,
  input  logic               q_msb_i,
  input  logic [bitsize-1:0] divisor_i,
  output logic [bitsize-1:0] r_next_o,
  output logic               q_bit_o
);
  logic [bitsize:0]   t;
  logic [bitsize-1:0] diff;

  // R < divisor on entry, so T < 2*divisor and T - divisor always fits in bitsize bits.
  always_comb begin
    t        = {r_i, q_msb_i};
    diff     = t[bitsize-1:0] - divisor_i;
    q_bit_o  = (t >= {1'b0, divisor_i});
    r_next_o = q_bit_o ? diff : t[bitsize-1:0];
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, valid/ready
// on both operand and result sides, divide-by-zero flagged with the result.
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int bitsize = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [bitsize-1:0] dividend,
  input  logic [bitsize-1:0] divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [bitsize-1:0] quotient,
  output logic [bitsize-1:0] remainder,
  output logic               div_by_zero
);
  localparam int CW = cnt_width(bitsize);
  localparam logic [CW-1:0] LAST = CW'(bitsize - 1);

  seq_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               zero_q, zero_d;
  logic [bitsize-1:0] r_q, r_d;
  logic [bitsize-1:0] qv_q, qv_d;
  logic [bitsize-1:0] dvs_q, dvs_d;
  logic [bitsize-1:0] quot_q, quot_d;
  logic [bitsize-1:0] rem_q, rem_d;
  logic               dbz_q, dbz_d;
  logic [bitsize-1:0] step_r;
  logic               step_bit;
  logic               accept;

  divstep_cell #(.bitsize(bitsize)) u_step (
    .r_i       (r_q),
    .q_msb_i   (qv_q[bitsize-1]),
    .divisor_i (dvs_q),
    .r_next_o  (step_r),
    .q_bit_o   (step_bit)
  );

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  always_ff @(posedge clk) begin
    r_q   <= r_d;
    qv_q  <= qv_d;
    dvs_q <= dvs_d;
  end

  // A zero divisor still spends one BUSY edge so its result appears one edge after accept.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_BUSY;
      ST_BUSY: if (zero_q || cnt_q == LAST) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
  end

  always_comb begin
    cnt_d  = cnt_q;
    zero_d = zero_q;
    r_d    = r_q;
    qv_d   = qv_q;
    dvs_d  = dvs_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    dbz_d  = dbz_q;
    if (state_q == ST_IDLE && accept) begin
      cnt_d  = '0;
      zero_d = (divisor == '0);
      r_d    = '0;
      qv_d   = dividend;
      dvs_d  = divisor;
      dbz_d  = 1'b0;
    end else if (state_q == ST_BUSY) begin
      if (zero_q) begin
        quot_d = '1;
        rem_d  = qv_q;
        dbz_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
        r_d   = step_r;
        qv_d  = {qv_q[bitsize-2:0], step_bit};
        if (cnt_q == LAST) begin
          quot_d = {qv_q[bitsize-2:0], step_bit};
          rem_d  = step_r;
        end
      end
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Bench for seq_restoring_divider: directed corner cases, then randomized
// traffic with random handshake gaps against an arithmetic reference model.
module tb_seq_restoring_divider;
  localparam int W    = 8;
  localparam int NRND = 3000;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready, div_by_zero;
  logic [W-1:0] dividend, divisor, quotient, remainder;

  typedef struct packed { logic [W-1:0] a; logic [W-1:0] b; } op_t;
  typedef struct packed { logic [W-1:0] q; logic [W-1:0] r; logic z; } res_t;

  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_res  = 0;
  bit   rnd_on = 1'b0;
  op_t  sb[$];
  op_t  mon_op;
  res_t mon_exp;

  always #5 clk = ~clk;

  seq_restoring_divider #(.bitsize(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
  endtask

  function automatic res_t ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
    res_t e;
    if (b == '0) begin
      e.q = '1; e.r = a; e.z = 1'b1;
    end else begin
      e.q = a / b; e.r = a % b; e.z = 1'b0;
    end
    return e;
  endfunction

  function automatic logic [W-1:0] rand_dvs();
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) return '0;
    if (k < 3) return W'($urandom_range(1, 3));
    return W'($urandom);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input int exp_lat, input int hold, input string tag);
    res_t e;
    int   lat;
    e   = ref_div(a, b);
    lat = 0;
    chk({tag, " in_ready idle"}, in_ready, 1);
    out_ready = 1'b0;
    dividend  = a;
    divisor   = b;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " quotient"}, quotient, e.q);
    chk({tag, " remainder"}, remainder, e.r);
    chk({tag, " div_by_zero"}, div_by_zero, e.z);
    chk({tag, " in_ready busy"}, in_ready, 0);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      dividend = W'($urandom);
      divisor  = W'($urandom);
      tick();
      chk({tag, " hold valid"}, out_valid, 1);
      chk({tag, " hold quotient"}, quotient, e.q);
      chk({tag, " hold remainder"}, remainder, e.r);
      chk({tag, " hold in_ready"}, in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, " released valid"}, out_valid, 0);
    chk({tag, " released in_ready"}, in_ready, 1);
  endtask

  task automatic reset_mid_op();
    bit rose;
    chk("rstmid in_ready idle", in_ready, 1);
    dividend = 8'd200;
    divisor  = 8'd7;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid in_ready", in_ready, 1);
    chk("rstmid out_valid", out_valid, 0);
    chk("rstmid quotient", quotient, 0);
    rose = 1'b0;
    repeat (12) begin
      tick();
      if (out_valid) rose = 1'b1;
    end
    chk("rstmid no result", rose, 0);
  endtask

  task automatic producer();
    int g;
    int waited;
    bit took;
    for (int i = 0; i < NRND; i++) begin
      g = $urandom_range(0, 3);
      repeat (g) tick();
      dividend = W'($urandom);
      divisor  = rand_dvs();
      in_valid = 1'b1;
      took     = 1'b0;
      waited   = 0;
      while (!took && waited < 100) begin
        @(negedge clk);
        took = in_ready;
        tick();
        waited++;
      end
      in_valid = 1'b0;
      if (!took) begin
        chk("rnd accept timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic consumer();
    int c;
    c = 0;
    while (n_res < NRND && c < 60000) begin
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
      c++;
    end
    out_ready = 1'b0;
    chk("rnd result count", n_res, NRND);
  endtask

  always @(negedge clk) begin
    if (rnd_on) begin
      if (in_valid && in_ready) sb.push_back('{a: dividend, b: divisor});
      if (out_valid && out_ready) begin
        n_res++;
        if (sb.size() == 0) begin
          chk("rnd spurious result", 1, 0);
        end else begin
          mon_op  = sb.pop_front();
          mon_exp = ref_div(mon_op.a, mon_op.b);
          if (mon_op.b != '0) begin
            chk("rnd q*d+r", 32'(quotient) * 32'(mon_op.b) + 32'(remainder), 32'(mon_op.a));
            chk("rnd r<d", remainder < mon_op.b, 1);
          end
          chk("rnd quotient", quotient, mon_exp.q);
          chk("rnd remainder", remainder, mon_exp.r);
          chk("rnd div_by_zero", div_by_zero, mon_exp.z);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) tick();
    rst = 1'b0;
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset quotient", quotient, 0);
    chk("reset remainder", remainder, 0);
    chk("reset div_by_zero", div_by_zero, 0);

    do_op(8'd200, 8'd7,   8, 0, "200/7");
    do_op(8'd255, 8'd1,   8, 0, "255/1");
    do_op(8'd5,   8'd9,   8, 0, "5/9");
    do_op(8'd0,   8'd3,   8, 0, "0/3");
    do_op(8'd255, 8'd255, 8, 0, "255/255");
    do_op(8'd77,  8'd0,   1, 0, "77/0");
    do_op(8'd10,  8'd3,   8, 0, "10/3");
    do_op(8'd100, 8'd9,   8, 5, "100/9");
    reset_mid_op();
    do_op(8'd9,   8'd2,   8, 0, "9/2");

    rnd_on = 1'b1;
    fork
      producer();
      consumer();
    join
    repeat (2) tick();
    rnd_on = 1'b0;
    chk("rnd scoreboard empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
